map_diff_scanner: RTL and testbench
===================================

Name: map_diff_scanner

Overview:
- Raster-scans a 16x12 game grid and encodes the object in the current cell into a 3-bit code.
- Compares each code against a stored copy of the frame last sent to the display.
- On a mismatch it stalls and issues one draw request, then waits for the display driver's cmd_done before resuming.
- Sits between the snake game logic, which answers "what is at (x,y)", and the display command engine.

Parameters:
- GRID_W, 16, number of columns; x range 0..15.
- GRID_H, 12, number of rows; y range 0..11.

Ports:
- clk  in  1  system clock, single domain.
- nrst  in  1  reset, synchronous, active-high.
- snakeHead  in  1  current cell (x,y) holds the snake head.
- snakeBody  in  1  current cell holds a snake body segment.
- apple  in  1  current cell holds the apple.
- border  in  1  current cell is a wall.
- mode_pb  in  1  mode pushbutton, already synchronized.
- GameOver  in  1  game-over flag.
- cmd_done  in  1  one-cycle pulse from the display engine: init or draw finished.
- x  out  4  current scan column.
- y  out  4  current scan row.
- obj_code  out  3  object code of the latched cell.
- diff  out  1  combinational: the encoded current cell differs from the stored frame.
- enable_loop  out  1  scan counter is advancing (state SCAN).
- en_update  out  1  one-cycle draw request for (x,y,obj_code).
- init_cycle  out  1  waiting for display initialization.
- sync_reset  out  1  one-cycle pulse: game/display restart.

Behaviour:
- Encoding, priority head>body>apple>border>empty:
  - head=001, body=010, apple=011, border=100, empty=000.
  - Codes 101–111 are never produced.
- Frame memory: 192 entries x 3 bits indexed [x][y], all 000 after reset or sync_reset.
- diff = (enc(inputs) != mem[x][y]). It is meaningful only in SCAN and is forced to 0 elsewhere.
- Reset (nrst=1 at a clk edge), all outputs except init_cycle go to 0:
  - state=INIT, x=0, y=0, obj_code=000, memory cleared.
  - en_update=0, enable_loop=0, sync_reset=0, init_cycle=1.
- INIT:
  - init_cycle=1; waits for cmd_done.
  - On cmd_done → SCAN with x=y=0.
- SCAN:
  - enable_loop=1.
  - If diff=0: advance x by 1 each cycle. At x=15, wrap x to 0 and advance y; at (15,11), wrap to (0,0) and continue scanning indefinitely.
  - If diff=1: hold x,y; latch obj_code=enc; write mem[x][y]=enc; go to UPDATE.
- UPDATE:
  - Lasts exactly one cycle: en_update=1, enable_loop=0.
  - → WAIT.
- WAIT:
  - en_update=0, enable_loop=0; x, y and obj_code held.
  - On cmd_done: advance to the next cell (same wrap rules) → SCAN.
- cmd_done arriving in SCAN or UPDATE is ignored.
- Only one draw is ever outstanding.
- Restart:
  - Trigger: a rising edge of mode_pb, or a rising edge of GameOver (edge detected on registered copies).
  - Effect: sync_reset=1 for one cycle, memory cleared, x=y=0, obj_code=000, state→INIT.
  - Takes priority over every state, including mid-WAIT.
  - Simultaneous edges of mode_pb and GameOver produce a single pulse.
- nrst has priority over the restart logic.
- Inputs are sampled the same cycle x,y are presented; the game logic must answer combinationally.

Decomposition:
- Package map_pkg:
  - obj_code_t enum: EMPTY=3'b000, HEAD=3'b001, BODY=3'b010, APPLE=3'b011, BORDER=3'b100.
  - GRID_W and GRID_H constants.
  - state_t enum: INIT, SCAN, UPDATE, WAIT.
- One sub-module is natural: map_frame_mem, a 192x3 register array with one combinational read port and one synchronous write port, plus a clear input.
- The encoder, counters and FSM stay in the top module.

Test Plan:
- Power-on: nrst high for 2 cycles, then low → x=0, y=0, init_cycle=1, enable_loop=0, en_update=0, sync_reset=0.
- Init exit and empty scan: cmd_done pulse in INIT, all object inputs 0 → init_cycle=0, enable_loop=1, and {x,y} steps 00,10,20,… (x increments every cycle); after 192 cycles it returns to (0,0) with no en_update.
- Single head:
  - Stimulus: snakeHead=1 only when (x,y)=(4,4).
  - Response: scan stops at 44h, diff=1, then next cycle en_update=1 for one cycle and obj_code=001; x,y hold at (4,4) through 50 idle cycles.
  - Then a cmd_done pulse → x=5 next cycle.
- Redraw suppression: same head at (4,4) on the next frame → no en_update. Head moved to (5,4) with body at (4,4) → updates at (4,4) code 010 and (5,4) code 001, in scan order.
- Border frame:
  - Stimulus: border=1 for x∈{0,15} or y∈{0,11}, each draw acknowledged with cmd_done.
  - Response: 52 en_update pulses in frame 1, each with obj_code=100; frame 2 produces 0 pulses.
- Restart: mode_pb rising edge while in WAIT at (6,4) → sync_reset=1 for one cycle, then x=y=0, init_cycle=1; a subsequent cmd_done redraws all non-empty cells. A GameOver rising edge produces the same sequence.

Source files
------------

// File: rtl/map_diff_scanner_pkg.sv
// -----------------------------------------------------------------------------
// map_pkg
// Shared types and constants for the map difference scanner.
//   GRID_W / GRID_H : playfield size in cells (16 columns x 12 rows)
//   obj_code_t      : 3-bit object code sent to the display engine
//   state_t         : scanner FSM states
//   encode_obj()    : priority encoder head > body > apple > border > empty
// -----------------------------------------------------------------------------
package map_pkg;

   localparam int GRID_W = 16;
   localparam int GRID_H = 12;

   typedef enum logic [2:0] {
      EMPTY  = 3'b000,
      HEAD   = 3'b001,
      BODY   = 3'b010,
      APPLE  = 3'b011,
      BORDER = 3'b100
   } obj_code_t;

   typedef enum logic [1:0] {
      INIT   = 2'b00,
      SCAN   = 2'b01,
      UPDATE = 2'b10,
      WAIT   = 2'b11
   } state_t;

   // Several flags may be set for one cell; the highest-priority one wins,
   // so codes 101..111 can never be produced.
   function automatic obj_code_t encode_obj(
      input logic head_in,
      input logic body_in,
      input logic apple_in,
      input logic border_in
   );
      obj_code_t code_v;
      if (head_in) begin
         code_v = HEAD;
      end else if (body_in) begin
         code_v = BODY;
      end else if (apple_in) begin
         code_v = APPLE;
      end else if (border_in) begin
         code_v = BORDER;
      end else begin
         code_v = EMPTY;
      end
      return code_v;
   endfunction

endpackage

// File: rtl/map_diff_scanner_if.sv
// -----------------------------------------------------------------------------
// map_diff_scanner_if
// Bundles every non-clock/reset signal of the scanner.
//   master : the scanner itself (drives scan position, draw request, status)
//   slave  : game logic + display engine side (answers cell contents,
//            acknowledges draws, supplies mode button / game-over flag)
// Signals:
//   snakeHead/snakeBody/apple/border : contents of cell (x,y), combinational
//   mode_pb, GameOver                : restart sources (level, edge-detected)
//   cmd_done                         : one-cycle init/draw finished pulse
//   x, y, obj_code                   : scan position and latched draw code
//   diff, enable_loop, en_update     : compare result, scanning, draw request
//   init_cycle, sync_reset           : waiting for display init, restart pulse
// -----------------------------------------------------------------------------
interface map_diff_scanner_if;

   logic       snakeHead;
   logic       snakeBody;
   logic       apple;
   logic       border;
   logic       mode_pb;
   logic       GameOver;
   logic       cmd_done;

   logic [3:0] x;
   logic [3:0] y;
   logic [2:0] obj_code;
   logic       diff;
   logic       enable_loop;
   logic       en_update;
   logic       init_cycle;
   logic       sync_reset;

   modport master (
      input  snakeHead, snakeBody, apple, border, mode_pb, GameOver, cmd_done,
      output x, y, obj_code, diff, enable_loop, en_update, init_cycle, sync_reset
   );

   modport slave (
      output snakeHead, snakeBody, apple, border, mode_pb, GameOver, cmd_done,
      input  x, y, obj_code, diff, enable_loop, en_update, init_cycle, sync_reset
   );

endinterface

// File: rtl/map_diff_scanner_frame_mem.sv
// -----------------------------------------------------------------------------
// map_frame_mem
// Copy of the frame last sent to the display: GRID_W x GRID_H cells of 3 bits,
// indexed [x][y].
//   clk     : system clock
//   clr     : synchronous clear of every cell to 000 (wins over a write)
//   we      : synchronous write enable
//   wr_x/y  : write address, wr_data : code to store
//   rd_x/y  : read address, rd_data : combinational read data
// -----------------------------------------------------------------------------
module map_frame_mem
   import map_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       we,
   input  logic [3:0] wr_x,
   input  logic [3:0] wr_y,
   input  logic [2:0] wr_data,
   input  logic [3:0] rd_x,
   input  logic [3:0] rd_y,
   output logic [2:0] rd_data
);

   logic [2:0] mem_r [GRID_W][GRID_H];

   // Combinational read so the compare happens in the same cycle the cell is presented.
   assign rd_data = mem_r[rd_x][rd_y];

   // Write port with whole-array clear for reset and game restart.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int ix = 0; ix < GRID_W; ix++) begin
            for (int iy = 0; iy < GRID_H; iy++) begin
               mem_r[ix][iy] <= 3'b000;
            end
         end
      end else if (we) begin
         mem_r[wr_x][wr_y] <= wr_data;
      end else begin
         mem_r[wr_x][wr_y] <= mem_r[wr_x][wr_y];
      end
   end

endmodule

// File: rtl/map_diff_scanner.sv
// -----------------------------------------------------------------------------
// map_diff_scanner
// Raster-scans the 16x12 grid, encodes each cell and compares it with the
// frame last sent to the display. A changed cell stalls the scan, raises one
// draw request and waits for the display engine to acknowledge it.
// Ports:
//   clk  : system clock
//   nrst : synchronous, active-high reset (name kept from the game codebase)
//   bus  : map_diff_scanner_if.master, see the interface for signal list
// -----------------------------------------------------------------------------
module map_diff_scanner
   import map_pkg::*;
(
   input  logic               clk,
   input  logic               nrst,
   map_diff_scanner_if.master bus
);

   localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
   localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

   state_t     state_r;
   logic [3:0] x_r;
   logic [3:0] y_r;
   obj_code_t  obj_code_r;
   logic       en_update_r;
   logic       enable_loop_r;
   logic       init_cycle_r;
   logic       sync_reset_r;
   logic       mode_pb_r;
   logic       game_over_r;

   obj_code_t  enc_s;
   logic [2:0] mem_rd_s;
   logic       diff_s;
   logic       restart_s;
   logic       mem_clr_s;
   logic       mem_we_s;
   logic [3:0] x_nxt_s;
   logic [3:0] y_nxt_s;

   // Encode the cell the game logic reports for the presented (x,y).
   always_comb begin
      enc_s = encode_obj(bus.snakeHead, bus.snakeBody, bus.apple, bus.border);
   end

   // Difference against the stored frame; only meaningful while scanning.
   always_comb begin
      diff_s = 1'b0;
      if (state_r == SCAN) begin
         diff_s = (3'(enc_s) != mem_rd_s);
      end else begin
         diff_s = 1'b0;
      end
   end

   // Rising edge on either source; simultaneous edges collapse into one restart.
   always_comb begin
      restart_s = (bus.mode_pb & ~mode_pb_r) | (bus.GameOver & ~game_over_r);
      mem_clr_s = nrst | restart_s;
      mem_we_s  = diff_s;
   end

   // Next raster position: x fastest, wrap (15,11) back to (0,0).
   always_comb begin
      x_nxt_s = x_r + 4'd1;
      y_nxt_s = y_r;
      if (x_r == X_LAST) begin
         x_nxt_s = 4'd0;
         if (y_r == Y_LAST) begin
            y_nxt_s = 4'd0;
         end else begin
            y_nxt_s = y_r + 4'd1;
         end
      end else begin
         x_nxt_s = x_r + 4'd1;
         y_nxt_s = y_r;
      end
   end

   // Previous-cycle copies for edge detection. They track the inputs even in
   // reset so a button held through reset is not seen as a fresh restart.
   always_ff @(posedge clk) begin
      mode_pb_r   <= bus.mode_pb;
      game_over_r <= bus.GameOver;
   end

   // Scanner FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_r       <= INIT;
         x_r           <= 4'd0;
         y_r           <= 4'd0;
         obj_code_r    <= EMPTY;
         en_update_r   <= 1'b0;
         enable_loop_r <= 1'b0;
         init_cycle_r  <= 1'b1;
         sync_reset_r  <= 1'b0;
      end else if (restart_s) begin
         // Restart overrides any state, including an outstanding draw.
         state_r       <= INIT;
         x_r           <= 4'd0;
         y_r           <= 4'd0;
         obj_code_r    <= EMPTY;
         en_update_r   <= 1'b0;
         enable_loop_r <= 1'b0;
         init_cycle_r  <= 1'b1;
         sync_reset_r  <= 1'b1;
      end else begin
         sync_reset_r <= 1'b0;
         case (state_r)
            INIT: begin
               if (bus.cmd_done) begin
                  state_r       <= SCAN;
                  x_r           <= 4'd0;
                  y_r           <= 4'd0;
                  init_cycle_r  <= 1'b0;
                  enable_loop_r <= 1'b1;
               end else begin
                  state_r       <= INIT;
                  init_cycle_r  <= 1'b1;
                  enable_loop_r <= 1'b0;
               end
            end
            SCAN: begin
               // cmd_done is deliberately not looked at here.
               if (diff_s) begin
                  state_r       <= UPDATE;
                  obj_code_r    <= enc_s;
                  en_update_r   <= 1'b1;
                  enable_loop_r <= 1'b0;
               end else begin
                  x_r <= x_nxt_s;
                  y_r <= y_nxt_s;
               end
            end
            UPDATE: begin
               state_r     <= WAIT;
               en_update_r <= 1'b0;
            end
            WAIT: begin
               if (bus.cmd_done) begin
                  state_r       <= SCAN;
                  x_r           <= x_nxt_s;
                  y_r           <= y_nxt_s;
                  enable_loop_r <= 1'b1;
               end else begin
                  state_r <= WAIT;
               end
            end
            default: begin
               state_r       <= INIT;
               x_r           <= 4'd0;
               y_r           <= 4'd0;
               obj_code_r    <= EMPTY;
               en_update_r   <= 1'b0;
               enable_loop_r <= 1'b0;
               init_cycle_r  <= 1'b1;
            end
         endcase
      end
   end

   map_frame_mem u_frame_mem (
      .clk     (clk),
      .clr     (mem_clr_s),
      .we      (mem_we_s),
      .wr_x    (x_r),
      .wr_y    (y_r),
      .wr_data (3'(enc_s)),
      .rd_x    (x_r),
      .rd_y    (y_r),
      .rd_data (mem_rd_s)
   );

   assign bus.x           = x_r;
   assign bus.y           = y_r;
   assign bus.obj_code    = 3'(obj_code_r);
   assign bus.diff        = diff_s;
   assign bus.enable_loop = enable_loop_r;
   assign bus.en_update   = en_update_r;
   assign bus.init_cycle  = init_cycle_r;
   assign bus.sync_reset  = sync_reset_r;

endmodule

// File: tb/tb_map_diff_scanner.sv
// -----------------------------------------------------------------------------
// tb_map_diff_scanner
// Self-checking bench for map_diff_scanner. A small game model answers cell
// queries combinationally from a grid of {head,body,apple,border} flags; the
// expected draw list of each frame is queued and checked as draws appear.
// -----------------------------------------------------------------------------
module tb_map_diff_scanner;

   logic tb_clk = 1'b0;
   logic nrst;

   map_diff_scanner_if bus ();

   map_diff_scanner dut (
      .clk  (tb_clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 tb_clk = ~tb_clk;

   // Game model: flags per cell {head, body, apple, border}.
   logic [3:0]  grid [16][12];
   // What the display is believed to show.
   logic [2:0]  sent [16][12];
   logic [10:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   assign bus.snakeHead = grid[bus.x][bus.y][3];
   assign bus.snakeBody = grid[bus.x][bus.y][2];
   assign bus.apple     = grid[bus.x][bus.y][1];
   assign bus.border    = grid[bus.x][bus.y][0];

   function automatic logic [2:0] ref_code(input logic [3:0] c);
      if (c[3]) return 3'd1;
      if (c[2]) return 3'd2;
      if (c[1]) return 3'd3;
      if (c[0]) return 3'd4;
      return 3'd0;
   endfunction

   task automatic clear_grid();
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 12; j++)
            grid[i][j] = 4'b0000;
   endtask

   task automatic clear_sent();
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 12; j++)
            sent[i][j] = 3'd0;
   endtask

   // Queue every cell whose code differs from what the display shows, in scan order.
   task automatic expect_frame();
      for (int j = 0; j < 12; j++) begin
         for (int i = 0; i < 16; i++) begin
            logic [2:0] c;
            c = ref_code(grid[i][j]);
            if (c != sent[i][j]) begin
               exp_q.push_back({4'(i), 4'(j), c});
               sent[i][j] = c;
            end
         end
      end
   endtask

   // Runs the scanner until all 192 cells have been passed, acknowledging draws.
   task automatic service_frame(input string name, input int start_adv, output int draws);
      int adv;
      int cyc;
      logic [10:0] exp_v;
      adv = start_adv;
      cyc = 0;
      draws = 0;
      while (adv < 192 && cyc < 3000) begin
         if (bus.en_update === 1'b1) begin
            draws++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s unexpected draw: got x=%0d y=%0d code=%0d, required no draw",
                        name, bus.x, bus.y, bus.obj_code);
            end else begin
               exp_v = exp_q.pop_front();
               if ({bus.x, bus.y, bus.obj_code} !== exp_v) begin
                  errors++;
                  $display("FAIL %s draw: got x=%0d y=%0d code=%0d, required x=%0d y=%0d code=%0d",
                           name, bus.x, bus.y, bus.obj_code, exp_v[10:7], exp_v[6:3], exp_v[2:0]);
               end
            end
            @(negedge tb_clk);
            bus.cmd_done = 1'b1;
            @(negedge tb_clk);
            bus.cmd_done = 1'b0;
            adv++;
            cyc += 2;
         end else begin
            if (bus.enable_loop === 1'b1 && bus.diff === 1'b0) adv++;
            @(negedge tb_clk);
            cyc++;
         end
      end
      checks++;
      if (adv < 192) begin
         errors++;
         $display("FAIL %s timeout: got %0d cells scanned, required 192", name, adv);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s missing draws: got %0d left over, required 0", name, exp_q.size());
      end
      exp_q.delete();
      checks++;
      if ({bus.x, bus.y} !== 8'h00) begin
         errors++;
         $display("FAIL %s frame end: got x=%0d y=%0d, required x=0 y=0", name, bus.x, bus.y);
      end
   endtask

   task automatic check_draws(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s draw count: got %0d, required %0d", name, got, want);
      end
   endtask

   // Leave INIT with a cmd_done pulse and check the scan starts at (0,0).
   task automatic init_exit(input string name);
      checks++;
      if (bus.init_cycle !== 1'b1) begin
         errors++;
         $display("FAIL %s before: got init_cycle=%b, required 1", name, bus.init_cycle);
      end
      bus.cmd_done = 1'b1;
      @(negedge tb_clk);
      bus.cmd_done = 1'b0;
      checks++;
      if ({bus.init_cycle, bus.enable_loop, bus.x, bus.y} !== {1'b0, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL %s after: got init_cycle=%b enable_loop=%b x=%0d y=%0d, required 0 1 0 0",
                  name, bus.init_cycle, bus.enable_loop, bus.x, bus.y);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b1;
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk);
      nrst = 1'b0;
      checks++;
      if ({bus.x, bus.y, bus.obj_code, bus.init_cycle, bus.enable_loop, bus.en_update, bus.sync_reset, bus.diff}
          !== {8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset: got x=%0d y=%0d code=%0d init=%b loop=%b upd=%b sync=%b diff=%b, required 0 0 0 1 0 0 0 0",
                  bus.x, bus.y, bus.obj_code, bus.init_cycle, bus.enable_loop, bus.en_update, bus.sync_reset, bus.diff);
      end
      @(negedge tb_clk);
      checks++;
      if ({bus.init_cycle, bus.enable_loop, bus.x, bus.y} !== {1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset hold: got init=%b loop=%b x=%0d y=%0d, required 1 0 0 0",
                  bus.init_cycle, bus.enable_loop, bus.x, bus.y);
      end
   endtask

   task automatic test_empty_scan();
      init_exit("init_exit");
      for (int i = 0; i < 192; i++) begin
         checks++;
         if (bus.x !== 4'(i % 16) || bus.y !== 4'(i / 16) || bus.en_update !== 1'b0 || bus.enable_loop !== 1'b1) begin
            errors++;
            $display("FAIL empty_scan step %0d: got x=%0d y=%0d upd=%b loop=%b, required x=%0d y=%0d upd=0 loop=1",
                     i, bus.x, bus.y, bus.en_update, bus.enable_loop, i % 16, i / 16);
         end
         // A stray cmd_done while scanning must change nothing.
         bus.cmd_done = (i == 20) ? 1'b1 : 1'b0;
         @(negedge tb_clk);
      end
      bus.cmd_done = 1'b0;
      checks++;
      if ({bus.x, bus.y} !== 8'h00) begin
         errors++;
         $display("FAIL empty_scan wrap: got x=%0d y=%0d, required 0 0", bus.x, bus.y);
      end
   endtask

   task automatic test_single_head();
      int cyc;
      int draws;
      logic held;
      logic [10:0] exp_v;
      grid[4][4] = 4'b1000;
      exp_q.push_back({4'd4, 4'd4, 3'd1});
      sent[4][4] = 3'd1;
      cyc = 0;
      while (bus.diff !== 1'b1 && cyc < 300) begin
         @(negedge tb_clk);
         cyc++;
      end
      checks++;
      if ({bus.x, bus.y, bus.diff, bus.enable_loop} !== {8'h44, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL head stop: got x=%0d y=%0d diff=%b loop=%b, required 4 4 1 1",
                  bus.x, bus.y, bus.diff, bus.enable_loop);
      end
      @(negedge tb_clk);
      checks++;
      if ({bus.en_update, bus.enable_loop} !== 2'b10) begin
         errors++;
         $display("FAIL head request: got upd=%b loop=%b, required 1 0", bus.en_update, bus.enable_loop);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.x, bus.y, bus.obj_code} !== exp_v) begin
         errors++;
         $display("FAIL head draw: got x=%0d y=%0d code=%0d, required x=4 y=4 code=1",
                  bus.x, bus.y, bus.obj_code);
      end
      // cmd_done during UPDATE is ignored; the draw stays outstanding.
      bus.cmd_done = 1'b1;
      @(negedge tb_clk);
      bus.cmd_done = 1'b0;
      held = 1'b1;
      repeat (50) begin
         @(negedge tb_clk);
         if ({bus.x, bus.y, bus.obj_code, bus.en_update, bus.enable_loop} !== {8'h44, 3'd1, 1'b0, 1'b0})
            held = 1'b0;
      end
      checks++;
      if (held !== 1'b1) begin
         errors++;
         $display("FAIL head hold: got held=%b (x=%0d y=%0d), required 1", held, bus.x, bus.y);
      end
      bus.cmd_done = 1'b1;
      @(negedge tb_clk);
      bus.cmd_done = 1'b0;
      checks++;
      if ({bus.x, bus.y, bus.enable_loop} !== {8'h54, 1'b1}) begin
         errors++;
         $display("FAIL head resume: got x=%0d y=%0d loop=%b, required 5 4 1", bus.x, bus.y, bus.enable_loop);
      end
      service_frame("head_rest", 69, draws);
      check_draws("head_rest", draws, 0);
   endtask

   task automatic test_back_to_back();
      int draws;
      expect_frame();
      service_frame("suppress", 0, draws);
      check_draws("suppress", draws, 0);
      grid[4][4] = 4'b0100;
      grid[5][4] = 4'b1000;
      expect_frame();
      service_frame("move", 0, draws);
      check_draws("move", draws, 2);
   endtask

   // Stop on the draw at (6,4), then hit a restart edge while it is outstanding.
   task automatic restart_in_wait(input string name, input logic use_go);
      int cyc;
      cyc = 0;
      while (bus.en_update !== 1'b1 && cyc < 400) begin
         @(negedge tb_clk);
         cyc++;
      end
      checks++;
      if ({bus.x, bus.y, bus.en_update} !== {8'h64, 1'b1}) begin
         errors++;
         $display("FAIL %s target: got x=%0d y=%0d upd=%b, required 6 4 1", name, bus.x, bus.y, bus.en_update);
      end
      @(negedge tb_clk);
      if (use_go) bus.GameOver = 1'b1;
      else        bus.mode_pb  = 1'b1;
      @(negedge tb_clk);
      checks++;
      if ({bus.sync_reset, bus.init_cycle, bus.x, bus.y, bus.obj_code} !== {1'b1, 1'b1, 8'h00, 3'd0}) begin
         errors++;
         $display("FAIL %s pulse: got sync=%b init=%b x=%0d y=%0d code=%0d, required 1 1 0 0 0",
                  name, bus.sync_reset, bus.init_cycle, bus.x, bus.y, bus.obj_code);
      end
      @(negedge tb_clk);
      checks++;
      if ({bus.sync_reset, bus.init_cycle, bus.enable_loop, bus.x, bus.y} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL %s after: got sync=%b init=%b loop=%b x=%0d y=%0d, required 0 1 0 0 0",
                  name, bus.sync_reset, bus.init_cycle, bus.enable_loop, bus.x, bus.y);
      end
      clear_sent();
      exp_q.delete();
   endtask

   task automatic test_restart_mode();
      int draws;
      grid[6][4] = 4'b0010;
      restart_in_wait("restart_mode", 1'b0);
      init_exit("restart_mode_init");
      expect_frame();
      service_frame("redraw", 0, draws);
      check_draws("redraw", draws, 3);
   endtask

   task automatic test_border();
      int draws;
      bus.mode_pb = 1'b0;
      @(negedge tb_clk);
      checks++;
      if (bus.sync_reset !== 1'b0) begin
         errors++;
         $display("FAIL falling edge: got sync=%b, required 0", bus.sync_reset);
      end
      grid[6][4] = 4'b0001;
      restart_in_wait("restart_gameover", 1'b1);
      clear_grid();
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 12; j++)
            if (i == 0 || i == 15 || j == 0 || j == 11) grid[i][j] = 4'b0001;
      init_exit("border_init");
      expect_frame();
      service_frame("border1", 0, draws);
      check_draws("border1", draws, 52);
      expect_frame();
      service_frame("border2", 0, draws);
      check_draws("border2", draws, 0);
   endtask

   task automatic test_priority();
      int draws;
      grid[4][4] = 4'b1001;
      grid[5][5] = 4'b0111;
      grid[7][7] = 4'b0011;
      grid[8][8] = 4'b1111;
      expect_frame();
      service_frame("priority", 0, draws);
      check_draws("priority", draws, 4);
   endtask

   task automatic test_simultaneous();
      bus.GameOver = 1'b0;
      repeat (2) @(negedge tb_clk);
      bus.GameOver = 1'b1;
      bus.mode_pb  = 1'b1;
      @(negedge tb_clk);
      checks++;
      if (bus.sync_reset !== 1'b1) begin
         errors++;
         $display("FAIL simultaneous pulse: got sync=%b, required 1", bus.sync_reset);
      end
      @(negedge tb_clk);
      // (0,0) is a border cell and memory was cleared, yet INIT forces diff low.
      checks++;
      if ({bus.sync_reset, bus.init_cycle, bus.diff} !== 3'b010) begin
         errors++;
         $display("FAIL simultaneous single: got sync=%b init=%b diff=%b, required 0 1 0",
                  bus.sync_reset, bus.init_cycle, bus.diff);
      end
      bus.GameOver = 1'b0;
      bus.mode_pb  = 1'b0;
      @(negedge tb_clk);
      nrst         = 1'b1;
      bus.mode_pb  = 1'b1;
      @(negedge tb_clk);
      checks++;
      if ({bus.sync_reset, bus.init_cycle} !== 2'b01) begin
         errors++;
         $display("FAIL reset priority: got sync=%b init=%b, required 0 1", bus.sync_reset, bus.init_cycle);
      end
      nrst = 1'b0;
   endtask

   initial begin
      nrst         = 1'b1;
      bus.mode_pb  = 1'b0;
      bus.GameOver = 1'b0;
      bus.cmd_done = 1'b0;
      clear_grid();
      clear_sent();
      test_reset();
      test_empty_scan();
      test_single_head();
      test_back_to_back();
      test_restart_mode();
      test_border();
      test_priority();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
